// File: rtl/muller_c_hs_driver.sv
// Clocked 4-phase initiator for an N-input Muller C-element: staggers req bits up/down, checks ack ordering.
// Optional HS_TIMEOUT_EN bounds the WAIT_HI/WAIT_LO waits; USE_POWER_PINS adds vccd1/vssd1.
module muller_c_hs_driver #(
  parameter int N           = 6,
  parameter int STEP_CYCLES = 1,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
`ifdef USE_POWER_PINS
  inout  wire          vccd1,
  inout  wire          vssd1,
`endif
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         ack_in,
  output logic [N-1:0] req_out,
  output logic         busy,
  output logic         done,
  output logic         ok,
  output logic         err_early,
  output logic         err_timeout,
  output logic [15:0]  pass_cnt
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(STEP_CYCLES + 1);
  localparam logic [N-1:0]  ONE    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] RELOAD = SW'(STEP_CYCLES - 1);
  localparam logic [IW-1:0] LAST   = IW'(N - 1);

  typedef enum logic [2:0] {IDLE, RISE, WAIT_HI, FALL, WAIT_LO} state_t;

  state_t              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [N-1:0]        req_q, req_d;
  logic [IW-1:0]       idx_q, idx_d, nxt;
  logic [SW-1:0]       step_q, step_d;
  logic                done_q, done_d, ok_q, ok_d;
  logic                ee_q, ee_d, et_q, et_d;
  logic [15:0]         pass_q, pass_d;
  logic                ack_s;
`ifdef HS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0]       to_q, to_d;
`endif

  assign sync_d = {sync_q[SYNC_STAGES-2:0], ack_in};
  assign ack_s  = sync_q[SYNC_STAGES-1];
  assign nxt    = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    idx_d   = idx_q;
    step_d  = step_q;
    done_d  = 1'b0;
    ok_d    = 1'b0;
    ee_d    = ee_q;
    et_d    = et_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: if (start) begin
        ee_d    = 1'b0;
        et_d    = 1'b0;
        req_d   = ONE;
        idx_d   = '0;
        step_d  = RELOAD;
        state_d = (N == 1) ? WAIT_HI : RISE;
      end
      RISE: begin
        // An ack while the request word is still partial means the C-element fired early.
        if (ack_s) begin
          ee_d    = 1'b1;
          req_d   = '0;
          state_d = WAIT_LO;
        end else if (step_q == '0) begin
          req_d  = req_q | (ONE << nxt);
          idx_d  = nxt;
          step_d = RELOAD;
          if (nxt == LAST) state_d = WAIT_HI;
        end else begin
          step_d = step_q - 1'b1;
        end
      end
      WAIT_HI: begin
        if (ack_s) begin
          req_d   = req_q & ~ONE;
          idx_d   = '0;
          step_d  = RELOAD;
          state_d = (N == 1) ? WAIT_LO : FALL;
        end
`ifdef HS_TIMEOUT_EN
        else if (to_q == TO_LAST) begin
          et_d    = 1'b1;
          req_d   = '0;
          state_d = WAIT_LO;
        end
`endif
      end
      FALL: begin
        if (!ack_s) begin
          ee_d    = 1'b1;
          req_d   = '0;
          state_d = WAIT_LO;
        end else if (step_q == '0) begin
          req_d  = req_q & ~(ONE << nxt);
          idx_d  = nxt;
          step_d = RELOAD;
          if (nxt == LAST) state_d = WAIT_LO;
        end else begin
          step_d = step_q - 1'b1;
        end
      end
      WAIT_LO: begin
        if (!ack_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ok_d    = !ee_q && !et_q;
          if (ok_d && pass_q != 16'hFFFF) pass_d = pass_q + 16'd1;
        end
`ifdef HS_TIMEOUT_EN
        else if (to_q == TO_LAST) begin
          et_d    = 1'b1;
          state_d = IDLE;
          done_d  = 1'b1;
          ok_d    = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef HS_TIMEOUT_EN
  always_comb begin
    to_d = '0;
    if (state_d == state_q && (state_q == WAIT_HI || state_q == WAIT_LO))
      to_d = to_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) to_q <= '0;
    else        to_q <= to_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= '0;
      req_q   <= '0;
      idx_q   <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      ee_q    <= 1'b0;
      et_q    <= 1'b0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      ee_q    <= ee_d;
      et_q    <= et_d;
      pass_q  <= pass_d;
    end
  end

  assign req_out     = req_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign ok          = ok_q;
  assign err_early   = ee_q;
  assign err_timeout = et_q;
  assign pass_cnt    = pass_q;
endmodule

// File: tb/tb_muller_c_hs_driver.sv
// Directed bench for muller_c_hs_driver: per-edge table for a clean handshake plus early-ack, reset and timeout sequences.
module tb_muller_c_hs_driver;
  logic       clk = 1'b0;
  logic       rst_n, start, ack_in;
  logic [5:0] req_out;
  logic       busy, done, ok, err_early, err_timeout;
  logic [15:0] pass_cnt;
`ifdef USE_POWER_PINS
  wire vccd1, vssd1;
`endif

  muller_c_hs_driver #(.N(6), .STEP_CYCLES(1), .SYNC_STAGES(2), .TIMEOUT(10)) dut (
`ifdef USE_POWER_PINS
    .vccd1(vccd1), .vssd1(vssd1),
`endif
    .clk(clk), .rst_n(rst_n), .start(start), .ack_in(ack_in), .req_out(req_out),
    .busy(busy), .done(done), .ok(ok), .err_early(err_early),
    .err_timeout(err_timeout), .pass_cnt(pass_cnt));

  always #5 clk = ~clk;

  // Ideal C-element: rises on all-ones, falls on all-zeros, holds otherwise.
  logic c_out = 1'b0;
  logic model_en, ack_man;
  always @(req_out) begin
    if (&req_out) c_out = 1'b1;
    else if (req_out == 6'b0) c_out = 1'b0;
  end
  assign ack_in = model_en ? c_out : ack_man;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       start;
    logic [5:0] req;
    logic       busy;
    logic       done;
    logic       ok;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_req(input logic [5:0] pat, input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (req_out == pat) begin got = 1'b1; break; end
      step();
    end
  endtask

  task automatic wait_done(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (done) begin got = 1'b1; break; end
    end
  endtask

  initial begin
    bit got;
    int ndone;
    logic [5:0] r;
    r = 6'b0;
    for (int k = 0; k < 6; k++) begin
      r[k] = 1'b1;
      tbl[k] = '{(k == 0), r, 1'b1, 1'b0, 1'b0};
    end
    tbl[6] = '{1'b0, 6'b111111, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 6'b111111, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      r[k] = 1'b0;
      tbl[8 + k] = '{1'b0, r, 1'b1, 1'b0, 1'b0};
    end
    tbl[14] = '{1'b0, 6'b0, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 6'b0, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 6'b0, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; model_en = 1'b1; ack_man = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {req_out, busy, done, ok, err_early, err_timeout, pass_cnt},
        {6'b0, 5'b0, 16'd0});
    rst_n = 1'b1;
    step();

    // Clean handshake, one row per clock edge.
    for (int k = 0; k < 17; k++) begin
      start = tbl[k].start;
      step();
      start = 1'b0;
      chk($sformatf("clean_row%0d", k), {req_out, busy, done, ok},
          {tbl[k].req, tbl[k].busy, tbl[k].done, tbl[k].ok});
    end
    chk("clean_pass_cnt", pass_cnt, 16'd1);
    step();
    chk("done_one_cycle", done, 1'b0);

    // Premature rise: ack asserted once req reaches 000111.
    model_en = 1'b0; ack_man = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    wait_req(6'b000111, 10, got);
    chk("rise_reach_000111", got, 1'b1);
    ack_man = 1'b1;
    step(); step();
    chk("rise_before_err", {req_out, err_early}, {6'b011111, 1'b0});
    step();
    chk("rise_err", {req_out, err_early, busy}, {6'b0, 1'b1, 1'b1});
    ack_man = 1'b0;
    wait_done(10, got);
    chk("rise_done", {got, ok}, {1'b1, 1'b0});
    chk("rise_pass_cnt", pass_cnt, 16'd1);

    // Premature fall: ack drops while req is 111100.
    model_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    chk("start_clears_err", err_early, 1'b0);
    wait_req(6'b111100, 20, got);
    chk("fall_reach_111100", got, 1'b1);
    ack_man = 1'b0; model_en = 1'b0;
    step(); step();
    chk("fall_before_err", {req_out, err_early}, {6'b110000, 1'b0});
    step();
    chk("fall_err", {req_out, err_early}, {6'b0, 1'b1});
    step();
    chk("fall_done", {done, ok}, {1'b1, 1'b0});
    chk("fall_pass_cnt", pass_cnt, 16'd1);
    model_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    chk("restart_clears_err", {err_early, req_out}, {1'b0, 6'b000001});
    wait_done(30, got);
    chk("recover_done", {got, ok, pass_cnt}, {1'b1, 1'b1, 16'd2});

    // Start pulsed during RISE is ignored.
    start = 1'b1; step(); start = 1'b0;
    step();
    start = 1'b1; step(); start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (done) ndone++;
    end
    chk("busy_start_one_done", ndone, 1);
    chk("busy_start_pass_cnt", pass_cnt, 16'd3);

    // Start in the done cycle is honoured.
    start = 1'b1; step(); start = 1'b0;
    wait_done(30, got);
    chk("b2b_first_done", {got, ok}, {1'b1, 1'b1});
    start = 1'b1; step(); start = 1'b0;
    chk("b2b_restart", {req_out, busy, done}, {6'b000001, 1'b1, 1'b0});
    wait_done(30, got);
    chk("b2b_second_done", {got, ok, pass_cnt}, {1'b1, 1'b1, 16'd5});

    // Asynchronous reset in the middle of FALL.
    start = 1'b1; step(); start = 1'b0;
    wait_req(6'b111000, 20, got);
    chk("rst_reach_111000", got, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {req_out, busy, pass_cnt, err_early}, {6'b0, 1'b0, 16'd0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    step();
    start = 1'b1; step(); start = 1'b0;
    wait_done(30, got);
    chk("post_rst_done", {got, ok, pass_cnt}, {1'b1, 1'b1, 16'd1});

`ifdef HS_TIMEOUT_EN
    // No ack at all: WAIT_HI expires 10 edges after entry.
    model_en = 1'b0; ack_man = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    repeat (14) step();
    chk("to_before", {err_timeout, req_out}, {1'b0, 6'b111111});
    step();
    chk("to_hi_fire", {err_timeout, req_out}, {1'b1, 6'b0});
    step();
    chk("to_done", {done, ok}, {1'b1, 1'b0});
    chk("to_pass_cnt", pass_cnt, 16'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
